// File: rtl/guess_game_pkg.sv
// Shared types for the number-guessing controller:
// FSM state encoding and comparator flag decode.
package guess_game_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        WAIT = 3'd2,
        WIN  = 3'd3,
        LOSE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        EQ,
        GT,
        LT,
        INVALID
    } flag_t;

    // Exactly one flag must be set; anything else is a comparator in reset or glitching
    function automatic flag_t decode_flags(
        input logic equal,
        input logic larger,
        input logic smaller
    );
        case ({equal, larger, smaller})
            3'b100:  return EQ;
            3'b010:  return GT;
            3'b001:  return LT;
            default: return INVALID;
        endcase
    endfunction

endpackage

// File: rtl/try_counter.sv
// Saturating attempt counter with synchronous clear and a flag
// raised when the value being loaded this cycle reaches MAX.
module try_counter #(
    parameter int MAX = 7,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         term
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clr)
            count_next = '0;
        else if (en && count != MAX_V)
            count_next = count + W'(1);
    end

    // Looks at the post-update value so the FSM can end the game on the same edge
    assign term = (count_next == MAX_V);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/guess_game_ctrl.sv
// Guess-game controller: consumes registered comparator flags,
// counts attempts, latches hints and declares win or lose.
module guess_game_ctrl #(
    parameter int MAX_TRIES = 7,
    parameter int TRY_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             guess_valid,
    input  logic             equal,
    input  logic             larger,
    input  logic             smaller,
    output logic             guess_ready,
    output logic             hint_high,
    output logic             hint_low,
    output logic             win,
    output logic             lose,
    output logic [TRY_W-1:0] attempts
);

    import guess_game_pkg::*;

    state_t state;
    flag_t  flag;
    logic   cnt_en;
    logic   term;

    assign flag   = decode_flags(equal, larger, smaller);
    assign cnt_en = (state == WAIT) && (flag != INVALID);

    try_counter #(
        .MAX (MAX_TRIES),
        .W   (TRY_W)
    ) u_try_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (start),
        .en    (cnt_en),
        .count (attempts),
        .term  (term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            guess_ready <= 1'b0;
            hint_high   <= 1'b0;
            hint_low    <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else if (start) begin
            state       <= PLAY;
            guess_ready <= 1'b1;
            hint_high   <= 1'b0;
            hint_low    <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                PLAY: begin
                    if (guess_valid) begin
                        state       <= WAIT;
                        guess_ready <= 1'b0;
                    end
                end
                WAIT: begin
                    unique case (flag)
                        EQ: begin
                            state     <= WIN;
                            win       <= 1'b1;
                            hint_high <= 1'b0;
                            hint_low  <= 1'b0;
                        end
                        GT, LT: begin
                            hint_high <= (flag == GT);
                            hint_low  <= (flag == LT);
                            if (term) begin
                                state <= LOSE;
                                lose  <= 1'b1;
                            end else begin
                                state       <= PLAY;
                                guess_ready <= 1'b1;
                            end
                        end
                        INVALID: begin
                            state       <= PLAY;
                            guess_ready <= 1'b1;
                        end
                    endcase
                end
                WIN, LOSE: ;
                default: begin
                    state       <= IDLE;
                    guess_ready <= 1'b0;
                    win         <= 1'b0;
                    lose        <= 1'b0;
                end
            endcase
        end
    end

endmodule
